seq_mult_8bit: RTL

// - Unsigned sequential shift-add multiplier for the MIPS_Archi datapath.
// - Computes P = A * B, one partial-product add per clock.
// - Sits directly downstream of the carry-lookahead adder and consumes its sum/carry every cycle.
// - Feeds the HI/LO result registers through a start/valid handshake.

---
 rtl/seq_mult_8bit.sv | 121 ++++++++++++
 1 files changed

// File: rtl/seq_mult_8bit.sv
// seq_mult_8bit: unsigned shift-add multiplier that does one partial-product add per clock.

// CLA_8bit: 8-bit carry-lookahead adder with group propagate/generate outputs.
module CLA_8bit (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Cin,
    output logic [7:0] Sum,
    output logic       Cout,
    output logic       PG,
    output logic       GG
);
    logic [7:0] g, p;
    logic [8:0] c;
    assign g = A & B;
    assign p = A ^ B;
    // Carries are built from the generate/propagate terms; GG is the group
    // generate with the carry-in treated as zero.
    always_comb begin
        c[0] = Cin;
        GG   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
            GG     = g[i] | (p[i] & GG);
        end
    end
    assign Sum  = p ^ c[7:0];
    assign Cout = c[8];
    assign PG   = &p;
endmodule

module seq_mult_8bit #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               ready,
    output logic               busy,
    output logic               valid,
    output logic [2*WIDTH-1:0] P
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, p_q, p_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [CW-1:0]      count_q, count_d;
    logic [WIDTH-1:0]   addend, sum;
    logic               cout;

    // The multiplier bit shifted to acc[0] decides whether mcand is added.
    assign addend = acc_q[0] ? mcand_q : '0;

    if (WIDTH == 8) begin : g_cla
        logic pg_unused, gg_unused;
        CLA_8bit u_cla (
            .A    (acc_q[2*WIDTH-1:WIDTH]),
            .B    (addend),
            .Cin  (1'b0),
            .Sum  (sum),
            .Cout (cout),
            .PG   (pg_unused),
            .GG   (gg_unused)
        );
    end else begin : g_add
        assign {cout, sum} = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    end

    // State and datapath registers; reset aborts any multiply in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            mcand_q <= '0;
            count_q <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            count_q <= count_d;
            p_q     <= p_d;
        end
    end

    // Next state: accept in IDLE, one add-and-shift per CALC edge, publish on the last.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        count_d = count_q;
        p_d     = p_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = CALC;
                mcand_d = A;
                acc_d   = {{WIDTH{1'b0}}, B};
                count_d = '0;
            end
            CALC: begin
                acc_d   = {cout, sum, acc_q[WIDTH-1:1]};
                count_d = count_q + 1'b1;
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    p_d     = acc_d;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ready = (state_q == IDLE);
    assign busy  = ~ready;
    assign valid = (state_q == DONE);
    assign P     = p_q;
endmodule
